// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 4-bit combinational ALU: one command in flight, operands read
// from a small register file, ALU result (or a fault) written back and reported on a strobe.
module alu_cmd_sequencer #(
    parameter int DATA_W   = 4,
    parameter int RF_DEPTH = 4,
    parameter int AW       = 2,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [3:0]        cmd_op,
    input  logic [AW-1:0]     cmd_src_a,
    input  logic [AW-1:0]     cmd_src_b,
    input  logic [AW-1:0]     cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_s,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [AW-1:0]     res_dst,
    output logic              res_err,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0]        OP_DIV     = 4'h3;
    localparam logic [3:0]        OP_MOD     = 4'h4;
    localparam logic [3:0]        OP_ILLEGAL = 4'hF;
    localparam logic [DATA_W-1:0] ZERO_D     = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;

    logic [DATA_W-1:0]   rf_r [RF_DEPTH];

    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [3:0]          alu_s_r;
    logic                load_r;
    logic [AW-1:0]       dst_r;
    logic [DATA_W-1:0]   imm_r;

    logic                ready_r;
    logic                res_valid_r;
    logic [DATA_W-1:0]   res_data_r;
    logic [AW-1:0]       res_dst_r;
    logic                res_err_r;
    logic [CNT_W-1:0]    op_count_r;

    logic                wr_en_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                wr_err_s;

    // Divide and modulo by a zero divisor are faults; the ALU output is meaningless then.
    function automatic logic is_div_zero(input logic [3:0] op, input logic [DATA_W-1:0] divisor);
        return ((op == OP_DIV) || (op == OP_MOD)) && (divisor == ZERO_D);
    endfunction

    // Next-state logic: a command is only accepted while idle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC:    state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Write-back decision for the latched command; a load wins over any opcode it carries.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = ZERO_D;
        wr_err_s  = 1'b0;
        if (load_r) begin
            wr_en_s   = 1'b1;
            wr_data_s = imm_r;
        end else if (alu_s_r == OP_ILLEGAL) begin
            wr_err_s  = 1'b1;
        end else if (is_div_zero(alu_s_r, alu_b_r)) begin
            wr_en_s   = 1'b1;
            wr_err_s  = 1'b1;
        end else begin
            wr_en_s   = 1'b1;
            wr_data_s = alu_y;
        end
    end

    // State register and registered ready (high exactly while idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                ready_r <= 1'b0;
            end else if (state_r == DONE) begin
                ready_r <= 1'b1;
            end else begin
                ready_r <= ready_r;
            end
        end
    end

    // Command capture: operands are sampled here, so src==dst sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r <= ZERO_D;
            alu_b_r <= ZERO_D;
            alu_s_r <= 4'h0;
            load_r  <= 1'b0;
            dst_r   <= {AW{1'b0}};
            imm_r   <= ZERO_D;
        end else if (accept_s) begin
            alu_a_r <= rf_r[cmd_src_a];
            alu_b_r <= rf_r[cmd_src_b];
            alu_s_r <= cmd_op;
            load_r  <= cmd_load;
            dst_r   <= cmd_dst;
            imm_r   <= cmd_imm;
        end else begin
            alu_a_r <= alu_a_r;
            alu_b_r <= alu_b_r;
            alu_s_r <= alu_s_r;
            load_r  <= load_r;
            dst_r   <= dst_r;
            imm_r   <= imm_r;
        end
    end

    // Register file: written once, at the edge closing EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_r[i] <= ZERO_D;
            end
        end else if ((state_r == EXEC) && wr_en_s) begin
            rf_r[dst_r] <= wr_data_s;
        end
    end

    // Result reporting and completed-command count (faulted commands count too).
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_data_r  <= ZERO_D;
            res_dst_r   <= {AW{1'b0}};
            res_err_r   <= 1'b0;
            op_count_r  <= {CNT_W{1'b0}};
        end else if (state_r == EXEC) begin
            res_valid_r <= 1'b1;
            res_data_r  <= wr_data_s;
            res_dst_r   <= dst_r;
            res_err_r   <= wr_err_s;
            op_count_r  <= op_count_r + ONE_C;
        end else begin
            res_valid_r <= 1'b0;
            res_data_r  <= res_data_r;
            res_dst_r   <= res_dst_r;
            res_err_r   <= res_err_r;
            op_count_r  <= op_count_r;
        end
    end

    assign cmd_ready = ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_s     = alu_s_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_dst   = res_dst_r;
    assign res_err   = res_err_r;
    assign op_count  = op_count_r;
    assign rd_data   = rf_r[rd_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural model predicts each result at issue,
// an independent monitor pops and compares whenever res_valid is seen.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [3:0] cmd_op;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [1:0] cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic [3:0] alu_y;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_dst;
    logic       res_err;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic [7:0] op_count;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .res_err(res_err),
        .rd_addr(rd_addr), .rd_data(rd_data), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [1:0] dst;
        logic       err;
        logic [3:0] rfv;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mrf [4];
    logic [7:0] mcnt;
    logic [1:0] peek_addr = 2'd0;
    int         last_waits;
    int         checks = 0;
    int         errors = 0;

    // Stand-in for the external ALU; divide/modulo by zero return junk on purpose.
    function automatic logic [3:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a * b;
            4'h3: return (b == 4'h0) ? 4'hF : a / b;
            4'h4: return (b == 4'h0) ? 4'hE : a % b;
            4'h5: return a & b;
            4'h6: return a | b;
            4'h7: return a ^ b;
            4'h8: return ~a;
            4'h9: return a << 1;
            4'hA: return a >> 1;
            4'hB: return b - a;
            4'hC: return a + 4'h1;
            4'hD: return a - 4'h1;
            4'hE: return (a > b) ? 4'h1 : 4'h0;
            default: return 4'h5;
        endcase
    endfunction

    always_comb alu_y = alu_ref(alu_s, alu_a, alu_b);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = 4'h0;
        mcnt = 8'h00;
        sb.delete();
    endtask

    task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] d, input logic [3:0] imm);
        exp_t e;
        int   waits;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op;
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_imm = imm;
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ready_low expected=ready_high at %0t", $time);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "command never accepted");
        end
        e.dst = d;
        e.err = 1'b0;
        if (ld) begin
            e.data = imm;
            mrf[d] = imm;
        end else if (op == 4'hF) begin
            e.data = 4'h0;
            e.err  = 1'b1;
        end else if ((op == 4'h3 || op == 4'h4) && mrf[b] == 4'h0) begin
            e.data = 4'h0;
            e.err  = 1'b1;
            mrf[d] = 4'h0;
        end else begin
            e.data = alu_ref(op, mrf[a], mrf[b]);
            mrf[d] = e.data;
        end
        mcnt  = mcnt + 8'h01;
        e.cnt = mcnt;
        e.rfv = mrf[d];
        sb.push_back(e);
        last_waits = waits;
        @(posedge clk);
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 8'(sb.size()), 8'h00);
    endtask

    task automatic peek(input logic [1:0] addr, input string name);
        peek_addr = addr;
        repeat (2) @(negedge clk);
        #2;
        check(name, 8'(rd_data), 8'(mrf[addr]));
    endtask

    // Monitor: compares every result strobe against the oldest prediction.
    initial begin
        exp_t e;
        logic prev_v = 1'b0;
        rd_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (res_valid) begin
                check("strobe_one_cycle", 8'(prev_v), 8'h00);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=res_valid expected=none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    rd_addr = e.dst;
                    #1;
                    check("res_data", 8'(res_data), 8'(e.data));
                    check("res_dst", 8'(res_dst), 8'(e.dst));
                    check("res_err", 8'(res_err), 8'(e.err));
                    check("rf_writeback", 8'(rd_data), 8'(e.rfv));
                    check("op_count", op_count, e.cnt);
                end
            end else begin
                rd_addr = peek_addr;
            end
            prev_v = res_valid;
        end
    end

    // Stimulus: directed test-plan cases, throughput, reset mid-command, then random wrap run.
    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 4'h0;
        cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0; cmd_imm = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 8'(cmd_ready), 8'h01);
        check("rst_res_valid", 8'(res_valid), 8'h00);
        check("rst_res_data", 8'(res_data), 8'h00);
        check("rst_res_dst", 8'(res_dst), 8'h00);
        check("rst_res_err", 8'(res_err), 8'h00);
        check("rst_op_count", op_count, 8'h00);
        check("rst_alu_a", 8'(alu_a), 8'h00);
        check("rst_alu_b", 8'(alu_b), 8'h00);
        check("rst_alu_s", 8'(alu_s), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) peek(2'(i), "rf_reset");

        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'h6);
        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd2, 4'h3);
        issue(1'b0, 4'h0, 2'd1, 2'd2, 2'd3, 4'h0);
        go_idle(1);
        drain();
        check("add_op_count", op_count, 8'h03);
        peek(2'd3, "add_r3");

        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd1, 4'hC);
        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd2, 4'h5);
        issue(1'b0, 4'h2, 2'd1, 2'd2, 2'd0, 4'h0);
        issue(1'b0, 4'h1, 2'd2, 2'd1, 2'd3, 4'h0);
        issue(1'b0, 4'h0, 2'd3, 2'd3, 2'd3, 4'h0);
        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd2, 4'h0);
        issue(1'b0, 4'h3, 2'd1, 2'd2, 2'd0, 4'h0);
        issue(1'b0, 4'h4, 2'd1, 2'd2, 2'd0, 4'h0);
        issue(1'b0, 4'hF, 2'd1, 2'd2, 2'd3, 4'h0);
        go_idle(1);
        drain();
        peek(2'd3, "illegal_r3_kept");

        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if (i > 0) check("ready_gap", 8'(last_waits), 8'h02);
        end
        go_idle(1);
        drain();

        issue(1'b1, 4'h0, 2'd0, 2'd0, 2'd2, 4'hA);
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_cmd_ready", 8'(cmd_ready), 8'h01);
        check("midrst_res_valid", 8'(res_valid), 8'h00);
        check("midrst_op_count", op_count, 8'h00);
        peek(2'd2, "midrst_r2");

        for (int i = 0; i < 256; i++) begin
            issue(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) go_idle($urandom_range(0, 2));
        end
        go_idle(1);
        drain();
        check("count_wrap", op_count, 8'h00);
        for (int i = 0; i < 4; i++) peek(2'(i), "final_rf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
